// File: rtl/pc_sequencer.sv
// Program-counter sequencer: a four-state fetch/execute controller.
//
// Parameters
//   RESET_VECTOR   program_counter value loaded on reset
//   FETCH_TIMEOUT  FETCH cycles without mem_ready before a fault (must be >= 1)
//
// Ports
//   clk            single clock, all state updates on the rising edge
//   is_powered_on  synchronous active-low reset
//   program_counter current instruction address
//   mem_req        fetch request (address = program_counter), high only in FETCH
//   mem_ready      memory returns mem_data this cycle
//   mem_data       fetched instruction word
//   instr          last fetched instruction, held
//   instr_valid    high throughout EXECUTE
//   stall          holds EXECUTE
//   jump_valid     take jump_target on EXECUTE exit
//   jump_target    next PC when jumping
//   halt           enter HALTED on EXECUTE exit
//   resume         leave HALTED
//   fault          fetch timeout occurred
//   state          IDLE=0, FETCH=1, EXECUTE=2, HALTED=3
//   retire_count   executed-instruction counter (wraps)
module pc_sequencer #(
  parameter logic [15:0] RESET_VECTOR  = 16'h0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        is_powered_on,
  output logic [15:0] program_counter,
  output logic        mem_req,
  input  logic        mem_ready,
  input  logic [15:0] mem_data,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        jump_valid,
  input  logic [15:0] jump_target,
  input  logic        halt,
  input  logic        resume,
  output logic        fault,
  output logic [1:0]  state,
  output logic [15:0] retire_count
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFetch   = 2'd1,
    StExecute = 2'd2,
    StHalted  = 2'd3
  } state_e;

  localparam int unsigned CntW = $clog2(FETCH_TIMEOUT + 1);
  // Value of the miss counter during the last miss cycle tolerated before faulting.
  localparam logic [CntW-1:0] CntLast = CntW'(FETCH_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [15:0]     pc_q, pc_d;
  logic [15:0]     instr_q, instr_d;
  logic            fault_q, fault_d;
  logic [15:0]     retire_q, retire_d;
  logic [CntW-1:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    fault_d    = fault_q;
    retire_d   = retire_q;
    miss_cnt_d = miss_cnt_q;

    unique case (state_q)
      StIdle: begin
        state_d    = StFetch;
        miss_cnt_d = '0;
      end
      StFetch: begin
        // A returning fetch wins over a timeout reached in the same cycle.
        if (mem_ready) begin
          instr_d = mem_data;
          state_d = StExecute;
        end else begin
          miss_cnt_d = miss_cnt_q + 1'b1;
          if (miss_cnt_q == CntLast) begin
            state_d = StHalted;
            fault_d = 1'b1;
          end
        end
      end
      StExecute: begin
        if (!stall) begin
          retire_d = retire_q + 16'd1;
          if (halt) begin
            state_d = StHalted;
          end else begin
            pc_d       = jump_valid ? jump_target : pc_q + 16'd1;
            state_d    = StFetch;
            miss_cnt_d = '0;
          end
        end
      end
      StHalted: begin
        if (resume) begin
          fault_d    = 1'b0;
          state_d    = StFetch;
          miss_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!is_powered_on) begin
      state_q    <= StIdle;
      pc_q       <= RESET_VECTOR;
      instr_q    <= 16'h0000;
      fault_q    <= 1'b0;
      retire_q   <= 16'h0000;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      fault_q    <= fault_d;
      retire_q   <= retire_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign program_counter = pc_q;
  assign instr           = instr_q;
  assign fault           = fault_q;
  assign retire_count    = retire_q;
  assign state           = state_q;
  assign mem_req         = (state_q == StFetch);
  assign instr_valid     = (state_q == StExecute);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by randomized traffic, every cycle
// checked against an integer reference model of the sequencing rules.
module tb_pc_sequencer;

  localparam logic [15:0] RV = 16'h0000;
  localparam int          TO = 16;

  logic        clk = 1'b0;
  logic        is_powered_on;
  logic [15:0] program_counter;
  logic        mem_req;
  logic        mem_ready;
  logic [15:0] mem_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        jump_valid;
  logic [15:0] jump_target;
  logic        halt;
  logic        resume;
  logic        fault;
  logic [1:0]  state;
  logic [15:0] retire_count;

  always #5 clk = ~clk;

  pc_sequencer #(
    .RESET_VECTOR  (RV),
    .FETCH_TIMEOUT (TO)
  ) dut (
    .clk             (clk),
    .is_powered_on   (is_powered_on),
    .program_counter (program_counter),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .mem_data        (mem_data),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .stall           (stall),
    .jump_valid      (jump_valid),
    .jump_target     (jump_target),
    .halt            (halt),
    .resume          (resume),
    .fault           (fault),
    .state           (state),
    .retire_count    (retire_count)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: 0 idle, 1 fetch, 2 execute, 3 halted.
  int m_st, m_pc, m_instr, m_fault, m_ret, m_miss;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (!is_powered_on) begin
      m_st = 0; m_pc = int'(RV); m_instr = 0; m_fault = 0; m_ret = 0; m_miss = 0;
    end else if (m_st == 0) begin
      m_st = 1; m_miss = 0;
    end else if (m_st == 1) begin
      if (mem_ready) begin
        m_instr = int'(mem_data); m_st = 2;
      end else begin
        m_miss = m_miss + 1;
        if (m_miss == TO) begin m_st = 3; m_fault = 1; end
      end
    end else if (m_st == 2) begin
      if (!stall) begin
        m_ret = (m_ret + 1) % 65536;
        if (halt) m_st = 3;
        else begin
          m_pc   = jump_valid ? int'(jump_target) : (m_pc + 1) % 65536;
          m_st   = 1;
          m_miss = 0;
        end
      end
    end else if (resume) begin
      m_fault = 0; m_st = 1; m_miss = 0;
    end
  endtask

  // Apply current inputs across one rising edge, then compare every output.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("state", {14'd0, state}, 16'(m_st));
    check("pc", program_counter, 16'(m_pc));
    check("instr", instr, 16'(m_instr));
    check("fault", {15'd0, fault}, 16'(m_fault));
    check("retire", retire_count, 16'(m_ret));
    check("mem_req", {15'd0, mem_req}, 16'(m_st == 1));
    check("instr_valid", {15'd0, instr_valid}, 16'(m_st == 2));
  endtask

  task automatic quiet();
    stall = 0; jump_valid = 0; halt = 0; resume = 0; jump_target = 16'h0000;
  endtask

  initial begin
    is_powered_on = 0; mem_ready = 0; mem_data = 16'hA000; quiet();
    m_st = 0; m_pc = 0; m_instr = 0; m_fault = 0; m_ret = 0; m_miss = 0;

    // Reset and release; mem_ready every FETCH, straight-line increments.
    step(); step();
    check("rst_state", {14'd0, state}, 16'd0);
    check("rst_pc", program_counter, RV);
    is_powered_on = 1; mem_ready = 1;
    for (int i = 0; i < 7; i++) begin
      mem_data = 16'hA000 + 16'(i);
      step();
    end
    check("seq_pc3", program_counter, 16'h0003);
    check("seq_ret3", retire_count, 16'd3);

    // Stall EXECUTE four cycles, then jump.
    stall = 1; step();
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_pc", program_counter, 16'h0003);
      check("stall_st", {14'd0, state}, 16'd2);
    end
    stall = 0; jump_valid = 1; jump_target = 16'h1234; step();
    check("jump_pc", program_counter, 16'h1234);
    check("jump_st", {14'd0, state}, 16'd1);

    // Wrap pc from FFFF to 0000.
    quiet(); step();
    jump_valid = 1; jump_target = 16'hFFFF; step();
    quiet(); step(); step();
    check("wrap_pc", program_counter, 16'h0000);
    check("wrap_fault", {15'd0, fault}, 16'd0);

    // Fetch returns on the last tolerated cycle: accepted, no fault.
    mem_ready = 0;
    for (int i = 0; i < TO - 1; i++) step();
    mem_ready = 1; mem_data = 16'h5A5A; step();
    check("late_st", {14'd0, state}, 16'd2);
    check("late_fault", {15'd0, fault}, 16'd0);
    step();

    // Timeout, then resume at the same pc.
    mem_ready = 0;
    for (int i = 0; i < TO - 1; i++) step();
    check("to_pre_st", {14'd0, state}, 16'd1);
    step();
    check("to_st", {14'd0, state}, 16'd3);
    check("to_fault", {15'd0, fault}, 16'd1);
    step();
    resume = 1; step(); resume = 0;
    check("res_fault", {15'd0, fault}, 16'd0);
    check("res_pc", program_counter, 16'h0001);

    // halt beats jump_valid.
    mem_ready = 1; step();
    halt = 1; jump_valid = 1; jump_target = 16'h7777; step();
    check("halt_st", {14'd0, state}, 16'd3);
    check("halt_pc", program_counter, 16'h0001);
    quiet(); resume = 1; step(); quiet();

    // Reset during a stalled EXECUTE at 0042.
    step();
    jump_valid = 1; jump_target = 16'h0042; step(); quiet();
    stall = 1; step(); step();
    is_powered_on = 0; step();
    check("rst2_st", {14'd0, state}, 16'd0);
    check("rst2_pc", program_counter, RV);
    check("rst2_ret", retire_count, 16'd0);
    is_powered_on = 1; quiet();

    // Randomized traffic.
    begin
      int rdy_pct;
      rdy_pct = 80;
      for (int i = 0; i < 2000; i++) begin
        if (i % 40 == 0) rdy_pct = int'($urandom_range(0, 100));
        is_powered_on = ($urandom_range(0, 99) != 0);
        mem_ready     = ($urandom_range(0, 99) < rdy_pct);
        mem_data      = 16'($urandom);
        stall         = ($urandom_range(0, 9) < 3);
        jump_valid    = ($urandom_range(0, 3) == 0);
        jump_target   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        halt          = ($urandom_range(0, 9) == 0);
        resume        = ($urandom_range(0, 9) < 3);
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
